// File: rtl/number_receiver.sv
// Byte-to-word receiver: packs three MSB-first bytes into 24-bit words and
// buffers them in a DEPTH-entry FIFO with ready/valid drain and sticky overflow.
module number_receiver #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [7:0]               number,
  input  logic                     flush,
  output logic [23:0]              word_q,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [7:0]      mid_q, mid_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [23:0]     mem_q [DEPTH];

  logic            push_req_s;
  logic            push_ok_s;
  logic            pop_s;
  logic            empty_s;
  logic            full_s;
  logic [23:0]     word_s;

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == CW'(DEPTH));
  assign word_s  = {hi_q, mid_q, number};

  // Assembly FSM state and byte holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BYTE0;
      hi_q    <= 8'h00;
      mid_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      mid_q   <= mid_d;
    end
  end

  // Assembly next-state: advance only on load; flush returns to BYTE0
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    mid_d      = mid_q;
    push_req_s = 1'b0;
    if (flush) begin
      state_d = BYTE0;
    end else if (load) begin
      case (state_q)
        BYTE0: begin
          hi_d    = number;
          state_d = BYTE1;
        end
        BYTE1: begin
          mid_d   = number;
          state_d = BYTE2;
        end
        BYTE2: begin
          push_req_s = 1'b1;
          state_d    = BYTE0;
        end
        default: begin
          state_d = BYTE0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Queue control: a pop frees the slot a same-cycle push needs when full
  always_comb begin
    pop_s     = !empty_s && word_ready && !flush;
    push_ok_s = push_req_s && (!full_s || pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_req_s && full_s && !pop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Word storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= word_s;
    end
  end

  assign word_valid = !empty_s;
  assign full       = full_s;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign word_q     = empty_s ? 24'h000000 : mem_q[rd_ptr_q];

endmodule

// File: doc/number_receiver.md
NUMBER_RECEIVER -- requirements
Module: number_receiver

Interface
REQ-001 Parameter DEPTH, default 4: number of 24-bit word slots in the output queue; power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load  input  1  byte strobe from the stimulus side; one byte accepted per cycle while high.
REQ-005 number  input  8  byte payload; sampled only when load=1.
REQ-006 flush  input  1  synchronous clear of assembly state, queue and overflow flag.
REQ-007 word_q  output  24  word at the queue head.
REQ-008 word_valid  output  1  queue non-empty; word_q is meaningful.
REQ-009 word_ready  input  1  consumer accepts word_q; a pop occurs when word_valid=1 and word_ready=1.
REQ-010 full  output  1  queue holds DEPTH words.
REQ-011 count  output  clog2(DEPTH)+1  words currently queued (0..DEPTH).
REQ-012 overflow  output  1  sticky: a completed word was dropped.

Function
REQ-013 Byte assembly SHALL use a 3-state FSM (BYTE0 -> BYTE1 -> BYTE2 -> BYTE0), advancing only on cycles with load=1.
REQ-014 Bytes SHALL pack MSB-first: BYTE0 -> bits 23:16, BYTE1 -> bits 15:8, BYTE2 -> bits 7:0.
REQ-015 A load in BYTE2 SHALL complete the word and push it into the queue at that same edge; FSM returns to BYTE0.
REQ-016 Latency: third byte at edge N with queue empty -> word_valid=1 and word_q correct immediately after edge N.
REQ-017 Push when full without a same-cycle pop: word dropped, queue and count unchanged, overflow set to 1, FSM returns to BYTE0.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when full (count unchanged, no overflow).
REQ-019 Pop when empty is impossible (word_valid=0); word_ready has no effect when empty.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-021 word_valid = (count != 0); full = (count == DEPTH); both derived from registered state only.
REQ-022 word_q SHALL hold stable while word_valid=1 and word_ready=0.
REQ-023 Words SHALL be delivered in strict arrival order; no duplication or reordering.
REQ-024 Bytes 0 and 1 SHALL be accepted regardless of full; only word completion is subject to REQ-017.
REQ-025 flush=1 SHALL, at the next edge, clear FSM to BYTE0, both pointers, count and overflow; a load or pop in the same cycle SHALL be ignored (flush wins).
REQ-026 overflow SHALL clear only on reset or flush.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM=BYTE0, pointers=0, count=0, word_valid=0, full=0, overflow=0, word_q=24'h000000.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after release, the next load is treated as BYTE0.
REQ-029 Queue storage contents need not be reset; word_q SHALL read 0 while the queue is empty.

Verification
REQ-030 Load 8'hA1, 8'hB2, 8'hC3 on consecutive cycles with word_ready=0 -> word_valid=1, word_q=24'hA1B2C3, count=1 after the third edge.
REQ-031 Load bytes with gaps (load low between them) -> same 24'hA1B2C3 result; FSM does not advance on idle cycles.
REQ-032 Fill DEPTH=4 words, then complete a 5th word with word_ready=0 -> full=1, count=4, overflow=1; head is still the first word.
REQ-033 With full=1, complete a word while word_ready=1 -> count stays 4, overflow stays 0, the new word lands at the tail.
REQ-034 Push 6 words while draining at one word per 2 cycles -> output order matches input order across pointer wrap.
REQ-035 Assert rst_n=0 after 2 bytes, release, send 3 bytes 8'h01, 8'h02, 8'h03 -> word_q=24'h010203, count=1.
